// File: rtl/mod_74x193_sync_if.sv
// Control and data bundle for the mod_74x193_sync counter.
// Optional feature macro: MOD_74X193_SYNC_OUTREG_EN (adds the rload strobe).
interface mod_74x193_sync_if #(
    parameter int WIDTH = 4
);
    logic             load_n;
    logic [WIDTH-1:0] d;
    logic             up;
    logic             enp;
    logic             ent;
`ifdef MOD_74X193_SYNC_OUTREG_EN
    logic             rload;
`endif
    logic [WIDTH-1:0] q;
    logic             co_n;
    logic             bo_n;

`ifdef MOD_74X193_SYNC_OUTREG_EN
    modport master (
        output load_n, d, up, enp, ent, rload,
        input  q, co_n, bo_n
    );
    modport slave (
        input  load_n, d, up, enp, ent, rload,
        output q, co_n, bo_n
    );
`else
    modport master (
        output load_n, d, up, enp, ent,
        input  q, co_n, bo_n
    );
    modport slave (
        input  load_n, d, up, enp, ent,
        output q, co_n, bo_n
    );
`endif
endinterface

// File: rtl/mod_74x193_sync.sv
// Synchronous presettable binary up/down counter (74x193-style), cascadable
// through active-low carry/borrow terminal-count outputs gated by ent.
// rst is the asynchronous, active-high clear.
// Optional feature macro: MOD_74X193_SYNC_OUTREG_EN
//   defined   : q comes from an output register loaded from the pre-update
//               count when rload is high at a clock edge.
//   undefined : q is the count itself.
module mod_74x193_sync #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    mod_74x193_sync_if.slave  bus
);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_reg;
    logic [WIDTH-1:0] cnt_next;
    logic             at_max;
    logic             at_zero;

    // Next count: load beats counting, counting needs both enables.
    always_comb begin
        cnt_next = cnt_reg;
        if (!bus.load_n) begin
            cnt_next = bus.d;
        end else if (bus.enp && bus.ent) begin
            cnt_next = bus.up ? (cnt_reg + ONE) : (cnt_reg - ONE);
        end
    end

    // Count register; clear acts immediately and holds while asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // Terminal-count detection is on the live count so a cascaded stage
    // sees its enable in the same cycle the lower stage is about to wrap.
    assign at_max   = &cnt_reg;
    assign at_zero  = ~|cnt_reg;
    assign bus.co_n = ~(bus.up  & bus.ent & at_max);
    assign bus.bo_n = ~(~bus.up & bus.ent & at_zero);

`ifdef MOD_74X193_SYNC_OUTREG_EN
    logic [WIDTH-1:0] oreg_reg;

    // Snapshot of the count as it stood before this edge's update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oreg_reg <= '0;
        end else if (bus.rload) begin
            oreg_reg <= cnt_reg;
        end
    end

    assign bus.q = oreg_reg;
`else
    assign bus.q = cnt_reg;
`endif

endmodule
